imem_responder: RTL and testbench

- Instruction-memory responder: the memory end of the instruction-fetch interface.
- Accepts a fetch address from the core-side fetch initiator. Returns the 32-bit instruction word after a configurable latency, using a valid/ready handshake on both request and response channels.
- Backed by a word-addressed internal array, filled through a separate load port before execution.
- Faulting fetches return an ebreak encoding so the core halts cleanly.

---
 rtl/imem_responder_if.sv | 20 ++
 rtl/imem_responder.sv | 100 ++++++++++
 tb/tb_imem_responder.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
// Fetch-side request/response channels between the core's fetch initiator and the instruction memory.
interface imem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: word array answering one fetch at a time; faults return ebreak.
// Latency: resp_valid rises LATENCY cycles after the request cycle (LATENCY-1 edges after acceptance).
// Backpressure: response held until resp_ready; req_ready falls through from resp_ready in RESP.
module imem_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h80000000,
    parameter int          LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    imem_responder_if.slave       bus,
    input  logic                  load_we,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data
);
    localparam int          WORDS    = 1 << DEPTH_LOG2;
    localparam logic [31:0] EBREAK   = 32'h00100073;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] resp_data_q;
    logic        resp_err_q;
    logic [31:0] mem [WORDS];

    logic        req_hs;
    logic        enter_resp;
    logic [31:0] rd_addr;
    logic [31:0] offset;
    logic        fault;
    wire         unused_off = ^offset[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_hs) state_nxt = (LATENCY == 1) ? RESP : WAIT;
            WAIT: if (cnt == 4'd1) state_nxt = RESP;
            RESP: if (bus.resp_ready)
                      state_nxt = bus.req_valid ? ((LATENCY == 1) ? RESP : WAIT) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        case (state)
            IDLE: bus.req_ready = 1'b1;
            RESP: begin
                bus.req_ready  = bus.resp_ready;
                bus.resp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign req_hs     = bus.req_valid && bus.req_ready;
    // Staying in RESP without a new acceptance must not reload the held word.
    assign enter_resp = (state_nxt == RESP) && ((state != RESP) || req_hs);
    // With LATENCY==1 the address being accepted on this edge is the one read.
    assign rd_addr    = req_hs ? bus.req_addr : addr_q;
    assign offset     = rd_addr - BASE_ADDR;
    assign fault      = (rd_addr[1:0] != 2'b00) || (offset[31:DEPTH_LOG2+2] != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            cnt         <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            if (req_hs) begin
                addr_q <= bus.req_addr;
                cnt    <= CNT_INIT;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                resp_data_q <= fault ? EBREAK : mem[offset[DEPTH_LOG2+1:2]];
                resp_err_q  <= fault;
            end
        end
    end

    // Contents survive rst; a same-edge load is seen only by later fetches.
    always_ff @(posedge clk) begin
        if (load_we) mem[load_addr] <= load_data;
    end

    assign bus.resp_data = resp_data_q;
    assign bus.resp_err  = resp_err_q;
endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder at default parameters (1024 words, base 0x80000000, latency 2).
module tb_imem_responder;
    localparam logic [31:0] BASE   = 32'h80000000;
    localparam logic [31:0] EBREAK = 32'h00100073;
    localparam logic [31:0] W0     = 32'h00500093;
    localparam logic [31:0] W1     = 32'h00a00113;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_we = 1'b0;
    logic [9:0] load_addr = '0;
    logic [31:0] load_data = '0;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    imem_responder_if bus ();

    imem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    always #5 clk = ~clk;

    task automatic load(input logic [9:0] idx, input logic [31:0] d);
        load_we = 1'b1; load_addr = idx; load_data = d;
        @(posedge clk); #1;
        load_we = 1'b0;
    endtask

    // Drives one request while the DUT is idle; optionally records its expected response.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic e, input bit push);
        exp_t x;
        x.d = d; x.e = e;
        if (push) sb.push_back(x);
        bus.req_addr = a; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (!bus.resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if ({bus.resp_valid, bus.resp_err} !== 2'b00) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00", {bus.resp_valid, bus.resp_err});
        end
        n_checks++;
        if (bus.resp_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 00000000", bus.resp_data);
        end
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int   n;
        exp_t x;
        logic [31:0] words [2];
        words[0] = W0; words[1] = W1;
        load(10'd0, W0);
        load(10'd1, W1);
        for (int i = 0; i < 2; i++) begin
            issue(BASE + 32'(4 * i), words[i], 1'b0, 1'b1);
            n_checks++;
            if (bus.resp_valid !== 1'b0) begin
                n_fail++; $display("FAIL basic_early_valid[%0d]: got %b expected 0", i, bus.resp_valid);
            end
            wait_resp(n);
            x = sb.pop_front();
            n_checks++;
            if (n !== 1 || bus.resp_valid !== 1'b1) begin
                n_fail++; $display("FAIL basic_latency[%0d]: got %0d edges expected 1", i, n);
            end
            n_checks++;
            if ({bus.resp_data, bus.resp_err} !== {x.d, x.e}) begin
                n_fail++; $display("FAIL basic_data[%0d]: got %h/%b expected %h/%b", i, bus.resp_data, bus.resp_err, x.d, x.e);
            end
            @(posedge clk); #1;
            n_checks++;
            if (bus.resp_valid !== 1'b0) begin
                n_fail++; $display("FAIL basic_idle[%0d]: got %b expected 0", i, bus.resp_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        int   n;
        exp_t x;
        bus.resp_ready = 1'b0;
        issue(BASE, W0, 1'b0, 1'b1);
        wait_resp(n);
        x = sb.pop_front();
        n_checks++;
        if (n !== 1) begin
            n_fail++; $display("FAIL bp_latency: got %0d edges expected 1", n);
        end
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({bus.resp_valid, bus.req_ready, bus.resp_data} !== {1'b1, 1'b0, x.d}) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v=%b rdy=%b d=%h expected v=1 rdy=0 d=%h",
                                   c, bus.resp_valid, bus.req_ready, bus.resp_data, x.d);
            end
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_fallthrough: got %b expected 1", bus.req_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({bus.resp_valid, bus.req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL bp_idle: got %b expected 01", {bus.resp_valid, bus.req_ready});
        end
    endtask

    task automatic test_back_to_back;
        int   n;
        exp_t x;
        exp_t y;
        issue(BASE, W0, 1'b0, 1'b1);
        wait_resp(n);
        x = sb.pop_front();
        n_checks++;
        if (bus.resp_data !== x.d) begin
            n_fail++; $display("FAIL b2b_first: got %h expected %h", bus.resp_data, x.d);
        end
        y.d = W1; y.e = 1'b0;
        sb.push_back(y);
        bus.req_addr = BASE + 32'd4; bus.req_valid = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready: got %b expected 1", bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n_checks++;
        if (bus.resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_gap: got %b expected 0", bus.resp_valid);
        end
        wait_resp(n);
        x = sb.pop_front();
        n_checks++;
        if (n !== 1 || {bus.resp_data, bus.resp_err} !== {x.d, x.e}) begin
            n_fail++; $display("FAIL b2b_second: got %0d edges %h/%b expected 1 edge %h/%b", n, bus.resp_data, bus.resp_err, x.d, x.e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_faults;
        int   n;
        exp_t x;
        logic [31:0] addrs [4];
        logic [31:0] datas [4];
        logic        errs  [4];
        addrs[0] = 32'h80000002; datas[0] = EBREAK;       errs[0] = 1'b1;
        addrs[1] = 32'h80001000; datas[1] = EBREAK;       errs[1] = 1'b1;
        addrs[2] = 32'h7FFFFFFC; datas[2] = EBREAK;       errs[2] = 1'b1;
        addrs[3] = 32'h80000FFC; datas[3] = 32'hCAFEF00D; errs[3] = 1'b0;
        load(10'd1023, 32'hCAFEF00D);
        for (int i = 0; i < 4; i++) begin
            issue(addrs[i], datas[i], errs[i], 1'b1);
            wait_resp(n);
            x = sb.pop_front();
            n_checks++;
            if ({bus.resp_valid, bus.resp_data, bus.resp_err} !== {1'b1, x.d, x.e}) begin
                n_fail++; $display("FAIL fault[%h]: got v=%b %h/%b expected v=1 %h/%b",
                                   addrs[i], bus.resp_valid, bus.resp_data, bus.resp_err, x.d, x.e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_collision;
        int   n;
        exp_t x;
        load(10'd3, 32'h11111111);
        issue(32'h8000000C, 32'h11111111, 1'b0, 1'b1);
        load_we = 1'b1; load_addr = 10'd3; load_data = 32'h22222222;
        @(posedge clk); #1;
        load_we = 1'b0;
        x = sb.pop_front();
        n_checks++;
        if ({bus.resp_valid, bus.resp_data} !== {1'b1, x.d}) begin
            n_fail++; $display("FAIL collision_old: got v=%b %h expected v=1 %h", bus.resp_valid, bus.resp_data, x.d);
        end
        @(posedge clk); #1;
        issue(32'h8000000C, 32'h22222222, 1'b0, 1'b1);
        wait_resp(n);
        x = sb.pop_front();
        n_checks++;
        if ({bus.resp_valid, bus.resp_data} !== {1'b1, x.d}) begin
            n_fail++; $display("FAIL collision_new: got v=%b %h expected v=1 %h", bus.resp_valid, bus.resp_data, x.d);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int   n;
        int   bad;
        exp_t x;
        issue(BASE, W0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.resp_valid, bus.req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL rst_wait_outputs: got %b expected 01", {bus.resp_valid, bus.req_ready});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.resp_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL rst_discard: got %0d valid cycles expected 0", bad);
        end
        issue(BASE, W0, 1'b0, 1'b1);
        wait_resp(n);
        x = sb.pop_front();
        n_checks++;
        if ({bus.resp_valid, bus.resp_data} !== {1'b1, x.d}) begin
            n_fail++; $display("FAIL rst_retained: got v=%b %h expected v=1 %h", bus.resp_valid, bus.resp_data, x.d);
        end
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        issue(BASE + 32'd4, W1, 1'b0, 1'b0);
        wait_resp(n);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.resp_valid, bus.resp_data, bus.resp_err} !== 34'h0) begin
            n_fail++; $display("FAIL rst_async_resp: got v=%b %h/%b expected v=0 00000000/0",
                               bus.resp_valid, bus.resp_data, bus.resp_err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_resp_idle: got %b expected 0", bus.resp_valid);
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.resp_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_faults();
        test_collision();
        test_reset_mid();
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
